// File: rtl/crc_serial_engine.sv
`default_nettype none
// ============================================================================
//  Module   : crc_serial_engine
//  Purpose  : Bit-serial CRC engine. Latches a K-bit word on a start
//             handshake and shifts up to K bits MSB-first, one per clock,
//             through a reflected-polynomial LFSR. Supports a configurable
//             initial value, a final XOR, multi-word chaining and an
//             expected-value compare.
//  Ports    :
//    clk       in   1   clock, rising edge
//    rst_n     in   1   synchronous active-low reset
//    start     in   1   process one word (accepted in IDLE or DONE)
//    cont      in   1   1: continue from current register, 0: load INIT
//    data_in   in   K   word, latched on accept
//    len       in   LW  bits to process (0 or >K means K), latched on accept
//    expected  in   W   compare value, latched on accept
//    busy      out  1   high while shifting
//    done      out  1   one-cycle result-valid pulse
//    count     out  LW  bits processed in current / last word
//    crc_out   out  W   register ^ XOR_OUT, held until next done / reset
//    match     out  1   crc_out == latched expected, held with crc_out
//  Revision : 1.0 - initial release
// ============================================================================
module crc_serial_engine #(
    parameter int             W       = 24,
    parameter logic [W-1:0]   POLY    = 24'h884110,
    parameter int             K       = 40,
    parameter logic [W-1:0]   INIT    = '0,
    parameter logic [W-1:0]   XOR_OUT = '0,
    localparam int            LW      = $clog2(K+1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cont,
    input  logic [K-1:0]  data_in,
    input  logic [LW-1:0] len,
    input  logic [W-1:0]  expected,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] count,
    output logic [W-1:0]  crc_out,
    output logic          match
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [LW-1:0] C_K   = LW'(K);
    localparam logic [LW-1:0] C_ONE = LW'(1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;

    // r_data is shifted left once per processed bit so the current data
    // bit is always at the MSB; this equals data_q[K-1-count].
    logic [K-1:0]  r_data;
    logic [W-1:0]  r_expected;
    logic [LW-1:0] r_len_eff;
    logic [LW-1:0] r_count;
    logic [W-1:0]  r_crc;
    logic [W-1:0]  r_crc_out;
    logic          r_match;

    logic          w_accept;
    logic [LW-1:0] w_len_eff;
    logic          w_fb;
    logic [W-1:0]  w_crc_next;
    logic [W-1:0]  w_crc_final;
    logic          w_last;

    assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_len_eff   = ((len == '0) || (len > C_K)) ? C_K : len;
    assign w_fb        = r_data[K-1] ^ r_crc[0];
    assign w_crc_next  = (r_crc >> 1) ^ (w_fb ? POLY : '0);
    assign w_crc_final = w_crc_next ^ XOR_OUT;
    assign w_last      = (r_count == (r_len_eff - C_ONE));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = start ? S_RUN : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. Accept and shift are mutually exclusive because accept is
    // only possible outside RUN; a start seen during RUN is ignored.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data     <= '0;
            r_expected <= '0;
            r_len_eff  <= C_K;
            r_count    <= '0;
            r_crc      <= INIT;
            r_crc_out  <= '0;
            r_match    <= 1'b0;
        end else if (w_accept) begin
            r_data     <= data_in;
            r_expected <= expected;
            r_len_eff  <= w_len_eff;
            r_count    <= '0;
            // Chaining keeps the register as left by the previous word.
            if (!cont) begin
                r_crc <= INIT;
            end
        end else if (r_state == S_RUN) begin
            r_data  <= r_data << 1;
            r_crc   <= w_crc_next;
            r_count <= r_count + C_ONE;
            if (w_last) begin
                r_crc_out <= w_crc_final;
                r_match   <= (w_crc_final == r_expected);
            end
        end
    end

    assign count   = r_count;
    assign crc_out = r_crc_out;
    assign match   = r_match;

endmodule
`default_nettype wire

// File: tb/tb_crc_serial_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crc_serial_engine
//  Purpose  : Self-checking bench for crc_serial_engine. Stimulus pushes the
//             expected result of each word into a queue; monitors pop and
//             compare whenever a done pulse appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_crc_serial_engine;

    typedef struct {
        logic [63:0] crc;
        logic        m;
        logic [15:0] cnt;
    } exp_t;

    exp_t q24[$];
    exp_t q16[$];

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance (W=24, K=40)
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cont  = 1'b0;
    logic [39:0] data_in  = '0;
    logic [5:0]  len      = '0;
    logic [23:0] expected = '0;
    logic        busy, done, match;
    logic [5:0]  count;
    logic [23:0] crc_out;

    crc_serial_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont),
        .data_in(data_in), .len(len), .expected(expected),
        .busy(busy), .done(done), .count(count),
        .crc_out(crc_out), .match(match)
    );

    // parameter variant (W=16, K=8)
    logic        s_start = 1'b0;
    logic        s_cont  = 1'b0;
    logic [7:0]  s_data  = '0;
    logic [3:0]  s_len   = '0;
    logic [15:0] s_exp   = '0;
    logic        s_busy, s_done, s_match;
    logic [3:0]  s_count;
    logic [15:0] s_crc;

    crc_serial_engine #(
        .W(16), .POLY(16'hA001), .K(8), .INIT(16'hFFFF), .XOR_OUT(16'h0000)
    ) dut16 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .cont(s_cont),
        .data_in(s_data), .len(s_len), .expected(s_exp),
        .busy(s_busy), .done(s_done), .count(s_count),
        .crc_out(s_crc), .match(s_match)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference bit-serial update for the 16-bit variant.
    function automatic logic [15:0] model16(input logic [15:0] init, input logic [7:0] d, input int n);
        logic [15:0] r;
        logic        fb;
        r = init;
        for (int i = 0; i < n; i++) begin
            fb = d[7-i] ^ r[0];
            r  = (r >> 1) ^ (fb ? 16'hA001 : 16'h0000);
        end
        return r;
    endfunction

    // Monitors: compare every done pulse against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (q24.size() == 0) begin
                chk("unexpected_done24", 64'd1, 64'd0);
            end else begin
                e = q24.pop_front();
                chk("crc24",   64'(crc_out), e.crc);
                chk("match24", 64'(match),   64'(e.m));
                chk("count24", 64'(count),   64'(e.cnt));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && s_done) begin
            if (q16.size() == 0) begin
                chk("unexpected_done16", 64'd1, 64'd0);
            end else begin
                e = q16.pop_front();
                chk("crc16",   64'(s_crc),   e.crc);
                chk("match16", 64'(s_match), 64'(e.m));
                chk("count16", 64'(s_count), 64'(e.cnt));
            end
        end
    end

    // Waits (bounded) for done; returns edges counted after the accept edge.
    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic run_word(input logic [39:0] d, input logic [5:0] l, input logic c,
                            input logic [23:0] ex, input logic [23:0] ecrc,
                            input logic em, input int ecnt);
        int n;
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1; cont = c; data_in = d; len = l; expected = ex;
        e.crc = 64'(ecrc); e.m = em; e.cnt = 16'(ecnt);
        q24.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
        chk("count_after_accept", 64'(count), 64'd0);
        wait_done(n);
        chk("latency", 64'(n), 64'(ecnt));
    endtask

    initial begin
        int   n;
        exp_t e;

        // reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  64'(busy),    64'd0);
        chk("rst_done",  64'(done),    64'd0);
        chk("rst_count", 64'(count),   64'd0);
        chk("rst_crc",   64'(crc_out), 64'd0);
        chk("rst_match", 64'(match),   64'd0);
        chk("rst_crc16", 64'(s_crc),   64'd0);
        rst_n = 1'b1;

        // zero data, full length
        run_word(40'h0, 6'd0, 1'b0, 24'h000000, 24'h000000, 1'b1, 40);
        // single bit
        run_word(40'h8000000000, 6'd1, 1'b0, 24'h0, 24'h884110, 1'b0, 1);
        // two bits, matching and non-matching compare
        run_word(40'h8000000000, 6'd2, 1'b0, 24'h442088, 24'h442088, 1'b1, 2);
        run_word(40'h8000000000, 6'd2, 1'b0, 24'h442089, 24'h442088, 1'b0, 2);
        // len > K treated as K
        run_word(40'h0, 6'd50, 1'b0, 24'h0, 24'h000000, 1'b1, 40);

        // chaining, second start held in the done cycle
        @(posedge clk); #1;
        start = 1'b1; cont = 1'b0; data_in = 40'h8000000000; len = 6'd1; expected = 24'h0;
        e.crc = 64'h884110; e.m = 1'b0; e.cnt = 16'd1;
        q24.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        chk("chain_w1_done", 64'(done), 64'd1);
        start = 1'b1; cont = 1'b1; data_in = 40'h0; len = 6'd1; expected = 24'h442088;
        e.crc = 64'h442088; e.m = 1'b1; e.cnt = 16'd1;
        q24.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        chk("chain_no_idle", 64'(busy), 64'd1);
        wait_done(n);
        chk("chain_latency", 64'(n), 64'd1);

        // start during RUN is ignored
        @(posedge clk); #1;
        start = 1'b1; cont = 1'b0; data_in = 40'h0; len = 6'd0; expected = 24'h0;
        e.crc = 64'h0; e.m = 1'b1; e.cnt = 16'd40;
        q24.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        start = 1'b1; cont = 1'b1; data_in = 40'hFFFFFFFFFF; len = 6'd1; expected = 24'h123456;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign_busy",  64'(busy),  64'd1);
        chk("ign_count", 64'(count), 64'd6);
        wait_done(n);
        chk("ign_latency", 64'(n + 6), 64'd40);

        // mid-run reset at the 10th shift edge
        @(posedge clk); #1;
        start = 1'b1; cont = 1'b0; data_in = 40'h8000000000; len = 6'd40; expected = 24'h0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        chk("pre_rst_count", 64'(count), 64'd9);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mrst_busy",  64'(busy),    64'd0);
        chk("mrst_count", 64'(count),   64'd0);
        chk("mrst_crc",   64'(crc_out), 64'd0);
        chk("mrst_done",  64'(done),    64'd0);
        repeat (45) @(posedge clk);
        run_word(40'h8000000000, 6'd1, 1'b0, 24'h884110, 24'h884110, 1'b1, 1);

        // parameter variant
        @(posedge clk); #1;
        s_start = 1'b1; s_cont = 1'b0; s_data = 8'h01; s_len = 4'd8;
        s_exp = model16(16'hFFFF, 8'h01, 8);
        e.crc = 64'(model16(16'hFFFF, 8'h01, 8)); e.m = 1'b1; e.cnt = 16'd8;
        q16.push_back(e);
        @(posedge clk); #1;
        s_start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        s_start = 1'b1; s_cont = 1'b0; s_data = 8'hA5; s_len = 4'd9; s_exp = 16'h0;
        e.crc = 64'(model16(16'hFFFF, 8'hA5, 8)); e.m = 1'b0; e.cnt = 16'd8;
        q16.push_back(e);
        @(posedge clk); #1;
        s_start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        s_start = 1'b1; s_cont = 1'b1; s_data = 8'h80; s_len = 4'd3; s_exp = 16'h0;
        e.crc = 64'(model16(model16(16'hFFFF, 8'hA5, 8), 8'h80, 3)); e.m = 1'b0; e.cnt = 16'd3;
        q16.push_back(e);
        @(posedge clk); #1;
        s_start = 1'b0;
        repeat (12) @(posedge clk);

        chk("q24_drained", 64'(q24.size()), 64'd0);
        chk("q16_drained", 64'(q16.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crc_serial_engine.md
# crc_serial_engine

Parametrised bit-serial CRC engine: the generic successor of the fixed 24-bit serial CRC shift register. It latches a K-bit word on a start handshake and shifts a programmable number of bits MSB-first through a reflected-polynomial LFSR, one bit per clock. It supports a configurable initial value, a final XOR, multi-word chaining and an expected-value compare. It sits between the frame assembler (word source) and the checker/transmit logic (CRC consumer).

## Interface
- W, 24: CRC register width (2..64).
- POLY, 24'h884110: reflected polynomial mask, W bits. Bit i set means the feedback is XORed into reg[i] after the shift. The default reproduces taps 4, 8, 14, 19, 23.
- K, 40: data word width (1..1024).
- INIT, 0: W-bit register value loaded on a fresh (non-chained) start and on reset.
- XOR_OUT, 0: W-bit mask XORed into the register when capturing crc_out.
- LW = $clog2(K+1), derived: width of len and count.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  request to process one word; accepted only in IDLE or DONE.
- cont  in  1  sampled with start. 1 means continue from the current register (chaining); 0 means load INIT.
- data_in  in  K  word, latched on accept.
- len  in  LW  number of bits to process, latched on accept. 0 or >K means K.
- expected  in  W  compare value, latched on accept.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the result is valid.
- count  out  LW  bits processed in the current or last word.
- crc_out  out  W  final CRC (register ^ XOR_OUT), registered and held until the next done or reset.
- match  out  1  crc_out == latched expected; updated with done and held.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --(count == len_eff-1 at the shift edge)--> DONE.
  - DONE --start--> RUN; DONE --no start--> IDLE.
- Accept, on an edge with start=1 in IDLE or DONE:
  - Latch data_in, expected and len_eff = (len == 0 || len > K) ? K : len.
  - count <= 0.
  - reg <= cont ? reg : INIT.
  - Nothing is shifted on the accept edge.
- Shift, on each RUN edge:
  - Data bit b = data_q[K-1-count], so processing is MSB-first from data_q[K-1] down to data_q[K-len_eff].
  - fb = b ^ reg[0].
  - reg <= (reg >> 1) ^ (fb ? POLY : 0).
  - count <= count + 1.
- Completion, on the last shift edge:
  - crc_out <= next_reg ^ XOR_OUT.
  - match <= ((next_reg ^ XOR_OUT) == expected_q).
  - State goes to DONE.
- The register is not cleared at done; a following start with cont=1 continues from it.
- start in RUN is ignored; there is no queueing and latched inputs are unchanged.
- Inputs other than start and cont are don't-care outside the accept edge.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, reg=INIT, busy=0, done=0, count=0, crc_out=0, match=0.
  - Reset overrides start.
  - A reset mid-RUN aborts the word with no done pulse.
- Accept edge E0 gives busy=1 from E0 and count=0.
- Shift edges are E1..E(len_eff); count=n after En.
- After E(len_eff): busy=0, done=1 for exactly one cycle, crc_out and match valid.
- Start-to-done latency is len_eff+1 edges; a K=40 full word takes 41.
- Back-to-back: start held during the done cycle is accepted at the next edge (DONE to RUN). The minimum period is len_eff+1 cycles per word.
- Arithmetic: count is LW bits and never exceeds K, with no wrap. The shift is logical right with a 0 fill before the POLY XOR.

## Test plan
- Zero data, defaults: start, data_in=0, len=0 (so K=40) -> done at the 41st edge after accept, crc_out=24'h000000, count=40.
- Single bit: data_in=40'h8000000000, len=1, cont=0 -> done after 2 edges, crc_out=24'h884110.
- Two bits: data_in=40'h8000000000, len=2 -> crc_out=24'h442088; with expected=24'h442088 -> match=1; with expected=24'h442089 -> match=0.
- Chaining:
  - Word 1: data_in=40'h8000000000, len=1, cont=0.
  - Word 2: data_in=0, len=1, cont=1, with start asserted in the done cycle.
  - Required: second done gives crc_out=24'h442088, and no IDLE cycle between the words.
- Ignored start and mid-run reset:
  - start pulses during RUN -> count and latched data unaffected.
  - rst_n=0 at the 10th shift edge of a len=40 word -> busy=0, count=0, crc_out=0, no done.
  - The next start completes normally.
- Parameter variant: W=16, POLY=16'hA001, INIT=16'hFFFF, K=8, data_in=8'h01, len=8 -> crc_out equals the software model of the MSB-first reflected update; the bench compares against that model.
